cr_kme_kop_dispatch: RTL and testbench

//  Downstream consumer of the 4-bit KME key-op FIFO. Pops one entry per op through a valid/ack port and issues it to the key engine over a req/gnt handshake.

---
 rtl/cr_kme_kop_dispatch.sv | 130 +++++++++++++
 tb/tb_cr_kme_kop_dispatch.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_kop_dispatch.sv
// Key-op dispatcher: pops KME key-op FIFO entries, issues them to the key engine under
// credit flow control and executes FENCE locally. Optional statistics: CR_KME_KOP_DISPATCH_STATS_EN.
module cr_kme_kop_dispatch #(
  parameter int CREDITS = 4,
  parameter int STAT_W  = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [3:0]                     in_data,
  input  logic                           in_valid,
  output logic                           in_ack,
  output logic                           eng_req,
  output logic [2:0]                     eng_op,
  output logic                           eng_last,
  input  logic                           eng_gnt,
  input  logic                           eng_done,
  output logic [$clog2(CREDITS+1)-1:0]   credit_avail,
  output logic                           frame_done,
  output logic                           credit_err,
  input  logic                           clr_err,
  output logic [STAT_W-1:0]              stat_ops,
  output logic [STAT_W-1:0]              stat_fences
);
  localparam int            CW       = $clog2(CREDITS+1);
  localparam logic [CW-1:0] FULL     = CW'(CREDITS);
  localparam logic [2:0]    OP_FENCE = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, FENCE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    op_q;
  logic [CW-1:0] credits;
  logic          gnt_acc;
  logic          fence_exit;
  logic          err_set;

  always_comb begin
    state_nxt  = state;
    in_ack     = 1'b0;
    eng_req    = 1'b0;
    eng_op     = '0;
    eng_last   = 1'b0;
    gnt_acc    = 1'b0;
    fence_exit = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && (credits != '0)) begin
          in_ack    = 1'b1;
          state_nxt = (in_data[2:0] == OP_FENCE) ? FENCE : ISSUE;
        end
      end
      ISSUE: begin
        eng_req  = 1'b1;
        eng_op   = op_q[2:0];
        eng_last = op_q[3];
        if (eng_gnt) begin
          gnt_acc   = 1'b1;
          state_nxt = IDLE;
        end
      end
      FENCE: begin
        // Fence drains only once every outstanding engine op has returned its credit.
        if (credits == FULL) begin
          fence_exit = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A done with nothing outstanding is an error unless a grant in the same cycle covers it.
  assign err_set = eng_done && !gnt_acc && (credits == FULL);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      credits    <= FULL;
      frame_done <= 1'b0;
      credit_err <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= (gnt_acc || fence_exit) && op_q[3];
      if (gnt_acc && !eng_done)
        credits <= credits - CW'(1);
      else if (eng_done && !gnt_acc && (credits != FULL))
        credits <= credits + CW'(1);
      if (err_set)
        credit_err <= 1'b1;
      else if (clr_err)
        credit_err <= 1'b0;
    end
  end

  // Held op is datapath only; state reset already discards it.
  always_ff @(posedge clk) begin
    if (in_ack)
      op_q <= in_data;
  end

  assign credit_avail = credits;

`ifdef CR_KME_KOP_DISPATCH_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  logic [STAT_W-1:0] ops_cnt;
  logic [STAT_W-1:0] fence_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_cnt   <= '0;
      fence_cnt <= '0;
    end else begin
      if (gnt_acc)
        ops_cnt <= sat_inc(ops_cnt);
      if (fence_exit)
        fence_cnt <= sat_inc(fence_cnt);
    end
  end

  assign stat_ops    = ops_cnt;
  assign stat_fences = fence_cnt;
`else
  assign stat_ops    = '0;
  assign stat_fences = '0;
`endif

endmodule

// File: tb/tb_cr_kme_kop_dispatch.sv
// Self-checking bench for cr_kme_kop_dispatch: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_cr_kme_kop_dispatch;
  localparam int CREDITS = 4;
  localparam int STAT_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [3:0]        in_data = 4'd0;
  logic              in_valid = 1'b0;
  logic              in_ack;
  logic              eng_req;
  logic [2:0]        eng_op;
  logic              eng_last;
  logic              eng_gnt = 1'b0;
  logic              eng_done = 1'b0;
  logic [2:0]        credit_avail;
  logic              frame_done;
  logic              credit_err;
  logic              clr_err = 1'b0;
  logic [STAT_W-1:0] stat_ops;
  logic [STAT_W-1:0] stat_fences;

  always #5 clk = ~clk;

  cr_kme_kop_dispatch #(.CREDITS(CREDITS), .STAT_W(STAT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ack(in_ack),
    .eng_req(eng_req), .eng_op(eng_op), .eng_last(eng_last), .eng_gnt(eng_gnt),
    .eng_done(eng_done), .credit_avail(credit_avail), .frame_done(frame_done),
    .credit_err(credit_err), .clr_err(clr_err), .stat_ops(stat_ops), .stat_fences(stat_fences)
  );

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  // Upstream FIFO contents and availability gate
  bit [3:0] src_q[$];
  bit       src_en = 1'b1;

  // Transaction-level model: one popped op pending at most, count of engine ops outstanding
  bit       m_ok   = 1'b0;
  bit       m_busy = 1'b0;
  bit [3:0] m_pend = 4'd0;
  int       m_out  = 0;
  bit       m_err  = 1'b0;
  bit       m_fd   = 1'b0;
  int       m_sops = 0;
  int       m_sfen = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic cycle(input bit g, input bit d, input bit c, input bit r);
    bit e_ack, e_req, is_fence, gnt, fexit, errset;
    @(negedge clk);
    cyc++;
    rst_n    = !r;
    eng_gnt  = g;
    eng_done = d;
    clr_err  = c;
    in_valid = src_en && (src_q.size() > 0);
    in_data  = in_valid ? src_q[0] : 4'($urandom);
    #1;
    is_fence = (m_pend[2:0] == 3'b111);
    e_ack    = !m_busy && in_valid && (m_out < CREDITS);
    e_req    = m_busy && !is_fence;
    if (m_ok) begin
      chk("in_ack", int'(in_ack), int'(e_ack));
      chk("eng_req", int'(eng_req), int'(e_req));
      chk("eng_op", int'(eng_op), e_req ? int'(m_pend[2:0]) : 0);
      chk("eng_last", int'(eng_last), e_req ? int'(m_pend[3]) : 0);
      chk("credit_avail", int'(credit_avail), CREDITS - m_out);
      chk("frame_done", int'(frame_done), int'(m_fd));
      chk("credit_err", int'(credit_err), int'(m_err));
`ifdef CR_KME_KOP_DISPATCH_STATS_EN
      chk("stat_ops", int'(stat_ops), m_sops);
      chk("stat_fences", int'(stat_fences), m_sfen);
`else
      chk("stat_ops", int'(stat_ops), 0);
      chk("stat_fences", int'(stat_fences), 0);
`endif
    end
    if (r) begin
      if (m_ok && e_ack) void'(src_q.pop_front());
      m_ok = 1'b1; m_busy = 1'b0; m_out = 0; m_err = 1'b0; m_fd = 1'b0;
      m_sops = 0; m_sfen = 0;
    end else if (m_ok) begin
      gnt    = e_req && g;
      fexit  = m_busy && is_fence && (m_out == 0);
      errset = d && !gnt && (m_out == 0);
      m_fd   = (gnt || fexit) && m_pend[3];
      if (gnt && m_sops < 65535) m_sops++;
      if (fexit && m_sfen < 65535) m_sfen++;
      if (gnt && !d) m_out++;
      else if (d && !gnt && m_out > 0) m_out--;
      m_err = errset ? 1'b1 : (c ? 1'b0 : m_err);
      if (gnt || fexit) m_busy = 1'b0;
      if (e_ack) begin
        m_busy = 1'b1;
        m_pend = src_q.pop_front();
      end
    end
  endtask

  initial begin
    bit g, d;
    // Reset state
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    chk("rst_in_ack", int'(in_ack), 0);
    chk("rst_eng_req", int'(eng_req), 0);
    chk("rst_credit_avail", int'(credit_avail), 4);
    chk("rst_credit_err", int'(credit_err), 0);

    // Single op with last flag
    src_q.push_back(4'b1010);
    cycle(0, 0, 0, 0);
    chk("t2_ack", int'(in_ack), 1);
    cycle(0, 0, 0, 0);
    chk("t2_req", int'(eng_req), 1);
    chk("t2_op", int'(eng_op), 2);
    chk("t2_last", int'(eng_last), 1);
    chk("t2_no_ack", int'(in_ack), 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t2_credits", int'(credit_avail), 3);
    chk("t2_frame_done", int'(frame_done), 1);
    cycle(0, 1, 0, 0);
    chk("t2_frame_done_once", int'(frame_done), 0);
    cycle(0, 0, 0, 0);
    chk("t2_credit_back", int'(credit_avail), 4);

    // Credit stall: 5 ops, 4 credits
    for (int i = 1; i <= 5; i++) src_q.push_back(4'(i));
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
    end
    cycle(0, 0, 0, 0);
    chk("t3_stall_ack", int'(in_ack), 0);
    chk("t3_zero_credit", int'(credit_avail), 0);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t3_fifth_ack", int'(in_ack), 1);
    cycle(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t3_drained", int'(credit_avail), 4);

    // Fence behind two outstanding ops
    src_q.push_back(4'b0011);
    src_q.push_back(4'b0100);
    src_q.push_back(4'b1111);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
    end
    cycle(0, 0, 0, 0);
    chk("t4_fence_ack", int'(in_ack), 1);
    cycle(0, 0, 0, 0);
    chk("t4_fence_noreq", int'(eng_req), 0);
    cycle(0, 1, 0, 0);
    chk("t4_fence_wait", int'(eng_req), 0);
    cycle(0, 1, 0, 0);
    chk("t4_no_early_fd", int'(frame_done), 0);
    cycle(0, 0, 0, 0);
    chk("t4_exit_fd_pending", int'(frame_done), 0);
    cycle(0, 0, 0, 0);
    chk("t4_frame_done", int'(frame_done), 1);
    chk("t4_credits", int'(credit_avail), 4);

    // Credit errors
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t5_err_set", int'(credit_err), 1);
    chk("t5_err_credits", int'(credit_avail), 4);
    src_q.push_back(4'b0110);
    cycle(0, 0, 0, 0);
    cycle(1, 1, 0, 0);
    cycle(0, 0, 0, 0);
    chk("t5_gnt_done_net0", int'(credit_avail), 4);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 0);
    chk("t5_clr", int'(credit_err), 0);
    cycle(0, 1, 1, 0);
    cycle(0, 0, 0, 0);
    chk("t5_err_wins", int'(credit_err), 1);
    cycle(0, 0, 1, 0);

    // Statistics after 3 ops and 1 fence
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    src_q.push_back(4'b0001);
    src_q.push_back(4'b0010);
    src_q.push_back(4'b0011);
    src_q.push_back(4'b0111);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0);
      cycle(1, 0, 0, 0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
`ifdef CR_KME_KOP_DISPATCH_STATS_EN
    chk("t6_stat_ops", int'(stat_ops), 3);
    chk("t6_stat_fences", int'(stat_fences), 1);
`else
    chk("t6_stat_ops", int'(stat_ops), 0);
    chk("t6_stat_fences", int'(stat_fences), 0);
`endif

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if (src_q.size() < 3 && $urandom_range(0, 2) == 0) src_q.push_back(4'($urandom));
      src_en = ($urandom_range(0, 7) != 0);
      g = 1'($urandom_range(0, 1));
      d = (m_out > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
      cycle(g, d, $urandom_range(0, 19) == 0, $urandom_range(0, 399) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
